msrv32_param_reg_file: RTL
==========================

Name: msrv32_param_reg_file

Overview:
- Parametrised successor to the core integer register file, used by pipeline stage 2 for reads and stage 3 for writeback.
- Generalised in data width, register count and number of read ports.
- Adds a post-reset sequential clear engine, so the storage array needs no async-reset flops.
- Adds a per-register pending scoreboard for in-flight writebacks, and keeps same-cycle write-to-read forwarding.

Parameters:
- XLEN, 32, data width of each register.
- NREG, 32, number of registers (power of 2, at least 2).
- AW, $clog2(NREG), register address width.
- NUM_RD, 2, number of combinational read ports (1 to 4).
- ZERO_REG, 1, when 1 register 0 always reads zero, is never written and is never pending.

Ports:
- clk_in  input  1  clock; all state updates on the rising edge.
- reset_n_in  input  1  asynchronous, active-low reset.
- rs_addr_in  input  NUM_RD*AW  packed read addresses; port k occupies bits [k*AW +: AW].
- rs_data_out  output  NUM_RD*XLEN  packed read data, combinational.
- rs_pend_out  output  NUM_RD  per-port flag: the addressed register awaits writeback.
- rd_addr_in  input  AW  write address.
- wr_en_in  input  1  write strobe.
- rd_in  input  XLEN  write data.
- rsv_en_in  input  1  reserve strobe; marks rsv_addr_in as pending.
- rsv_addr_in  input  AW  register to reserve.
- ready_out  output  1  high once the post-reset clear has finished.
- wr_drop_out  output  1  sticky flag: a write or reserve was dropped because the block was not ready.

Behaviour:
- Asynchronous reset (reset_n_in low), applied immediately:
  - FSM goes to INIT and the clear counter to 0.
  - All pending bits go to 0.
  - ready_out=0 and wr_drop_out=0.
  - rs_data_out reads all-zero; rs_pend_out=0.
  - The storage array is not reset.
- FSM state INIT:
  - Each cycle, entry[cnt] is written with 0 and cnt increments.
  - When cnt==NREG-1, that entry is cleared and the FSM moves to READY.
  - ready_out goes high on the NREG-th rising edge after reset release.
- FSM state READY: terminal; the FSM leaves it only on reset.
- Reset asserted mid-INIT: the clear restarts from entry 0.
- Reads while in INIT: every port returns 0 and pend=0.
- wr_en_in or rsv_en_in while in INIT:
  - the request is ignored;
  - wr_drop_out sets on that edge and holds until reset.
- Write in READY: on the rising edge, entry[rd_addr_in] <= rd_in. A write to address 0 is discarded when ZERO_REG=1.
- Forwarding, per port k, applies when wr_en_in is high, rd_addr_in equals port k's address, READY, and the address is non-zero (or ZERO_REG=0):
  - rs_data_out[k] = rd_in in the same cycle;
  - rs_pend_out[k] = 0.
- Read without forwarding: rs_data_out[k] = entry[addr]. Address 0 returns 0 when ZERO_REG=1.
- Scoreboard:
  - rsv_en_in sets pend[rsv_addr_in] on the edge.
  - wr_en_in clears pend[rd_addr_in] on the edge.
  - Same register reserved and written in one cycle: the set wins (a new producer has been issued).
  - Reserve and write to different registers in one cycle: both take effect.
  - Reserving an already-pending register is legal and leaves it pending.
  - When ZERO_REG=1, reserve of address 0 is ignored and pend[0] stays 0.
- rs_pend_out[k] = pend[addr], except 0 when forwarding is active on port k.
- Read latency is 0 cycles. A write is visible through the array 1 cycle later and through forwarding in the same cycle.

Optional Feature:
- Macro: MSRV32_REGFILE_PARITY_EN.
- When defined:
  - each entry stores one extra even-parity bit, computed from rd_in on write and as 0 during INIT;
  - a new output parity_err_out (width NUM_RD) flags a parity mismatch on a non-forwarded read of port k;
  - parity_err_out is combinational and forced 0 in INIT, for forwarded reads, and for x0 when ZERO_REG=1.
- When not defined: no parity storage, and the parity_err_out port does not exist.

Test Plan:
- Reset hold, release, count cycles with NREG=32 -> ready_out rises on the 32nd edge; all reads return 0 before and after.
- In READY, write x5=0xDEADBEEF while port0 reads x5 in the same cycle -> port0 returns 0xDEADBEEF that cycle and on the next cycle from the array.
- Write x0=0x12345678 with ZERO_REG=1, then read x0 on both ports -> 0x00000000; rs_pend_out=0.
- Reserve x7, next cycle read x7 -> pend=1; then write x7=0xA5 -> pend=0 with data 0xA5 in the write cycle; reserve and write x7 together -> pend=1 next cycle.
- wr_en_in=1 on the 3rd cycle of INIT -> write ignored, wr_drop_out=1; after ready_out rises, the targeted register reads 0; wr_drop_out stays 1 until reset.
- Parity build (MSRV32_REGFILE_PARITY_EN): force-flip a stored bit of x3, read x3 -> parity_err_out[0]=1; a forwarded read of x3 in the same cycle -> 0.

Source files
------------

// File: rtl/msrv32_param_reg_file.sv
// msrv32_param_reg_file: parametrised register file with post-reset clear engine,
// pending-writeback scoreboard and write forwarding. Optional MSRV32_REGFILE_PARITY_EN.
`default_nettype none

module msrv32_param_reg_file #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int AW       = $clog2(NREG),
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                   clk_in,
  input  logic                   reset_n_in,
  input  logic [NUM_RD*AW-1:0]   rs_addr_in,
  output logic [NUM_RD*XLEN-1:0] rs_data_out,
  output logic [NUM_RD-1:0]      rs_pend_out,
  input  logic [AW-1:0]          rd_addr_in,
  input  logic                   wr_en_in,
  input  logic [XLEN-1:0]        rd_in,
  input  logic                   rsv_en_in,
  input  logic [AW-1:0]          rsv_addr_in,
`ifdef MSRV32_REGFILE_PARITY_EN
  output logic [NUM_RD-1:0]      parity_err_out,
`endif
  output logic                   ready_out,
  output logic                   wr_drop_out
);

`ifdef MSRV32_REGFILE_PARITY_EN
  localparam int EW = XLEN + 1;
`else
  localparam int EW = XLEN;
`endif

  typedef enum logic [0:0] {
    INIT  = 1'b0,
    READY = 1'b1
  } state_t;

  state_t            state;
  logic [AW-1:0]     cnt;
  logic [NREG-1:0]   pend;
  logic [NREG-1:0]   pend_nxt;
  logic              drop;
  logic [EW-1:0]     mem [NREG];
  logic [EW-1:0]     wr_entry;
  logic              rd_zero;
  logic              rsv_zero;

  assign rd_zero  = (ZERO_REG != 0) && (rd_addr_in == '0);
  assign rsv_zero = (ZERO_REG != 0) && (rsv_addr_in == '0);

`ifdef MSRV32_REGFILE_PARITY_EN
  assign wr_entry = {^rd_in, rd_in};
`else
  assign wr_entry = rd_in;
`endif

  // Clearing the reservation first lets a same-cycle reserve of the same register win.
  always_comb begin
    pend_nxt = pend;
    if (wr_en_in) begin
      pend_nxt[rd_addr_in] = 1'b0;
    end
    if (rsv_en_in && !rsv_zero) begin
      pend_nxt[rsv_addr_in] = 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state <= INIT;
      cnt   <= '0;
      pend  <= '0;
      drop  <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          if (wr_en_in || rsv_en_in) begin
            drop <= 1'b1;
          end
          if (cnt == AW'(NREG - 1)) begin
            state <= READY;
          end
          cnt <= cnt + 1'b1;
        end
        READY: begin
          pend <= pend_nxt;
        end
        default: state <= INIT;
      endcase
    end
  end

  // Storage carries no reset; the INIT sweep zeroes it instead.
  always_ff @(posedge clk_in) begin
    if (state == INIT) begin
      mem[cnt] <= '0;
    end else if (wr_en_in && !rd_zero) begin
      mem[rd_addr_in] <= wr_entry;
    end
  end

  assign ready_out   = (state == READY);
  assign wr_drop_out = drop;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0] addr;
    logic          is_zero;
    logic          fwd;
    logic [EW-1:0] entry;

    assign addr    = rs_addr_in[k*AW +: AW];
    assign is_zero = (ZERO_REG != 0) && (addr == '0);
    assign fwd     = ready_out && wr_en_in && (rd_addr_in == addr) && !is_zero;
    assign entry   = mem[addr];

    always_comb begin
      if (!ready_out || is_zero) begin
        rs_data_out[k*XLEN +: XLEN] = '0;
      end else if (fwd) begin
        rs_data_out[k*XLEN +: XLEN] = rd_in;
      end else begin
        rs_data_out[k*XLEN +: XLEN] = entry[XLEN-1:0];
      end
    end

    assign rs_pend_out[k] = ready_out && !fwd && !is_zero && pend[addr];

`ifdef MSRV32_REGFILE_PARITY_EN
    assign parity_err_out[k] = ready_out && !fwd && !is_zero && (^entry);
`endif
  end

endmodule

`default_nettype wire
